// File: rtl/complete_cdb_arbiter_if.sv
// rtl/complete_cdb_arbiter_if.sv - FU completion channels in, CDB lanes and fu_free out.
interface complete_cdb_arbiter_if #(
  parameter int NUM_CH = 8,
  parameter int CDB_W  = 2,
  parameter int XLEN   = 32,
  parameter int PREG_W = 6,
  parameter int ROB_W  = 5
);
  logic [NUM_CH-1:0]        in_valid;
  logic [NUM_CH*PREG_W-1:0] in_dest_idx;
  logic [NUM_CH*XLEN-1:0]   in_result;
  logic [NUM_CH*XLEN-1:0]   in_npc;
  logic [NUM_CH-1:0]        in_take_br;
  logic [NUM_CH*ROB_W-1:0]  in_rob_idx;
  logic [NUM_CH-1:0]        in_ready;

  logic [CDB_W-1:0]         cdb_valid;
  logic [CDB_W-1:0]         cdb_wr_en;
  logic [CDB_W*PREG_W-1:0]  cdb_idx;
  logic [CDB_W*XLEN-1:0]    cdb_data;
  logic [CDB_W*ROB_W-1:0]   cdb_rob_idx;
  logic [NUM_CH-1:0]        fu_free;

  modport slave (
    input  in_valid, in_dest_idx, in_result, in_npc, in_take_br, in_rob_idx,
    output in_ready, cdb_valid, cdb_wr_en, cdb_idx, cdb_data, cdb_rob_idx, fu_free
  );

  modport master (
    output in_valid, in_dest_idx, in_result, in_npc, in_take_br, in_rob_idx,
    input  in_ready, cdb_valid, cdb_wr_en, cdb_idx, cdb_data, cdb_rob_idx, fu_free
  );
endinterface

// File: rtl/complete_cdb_arbiter.sv
// rtl/complete_cdb_arbiter.sv - per-channel 1-entry buffers broadcast on CDB_W lanes by rotating priority.
// Optional same-cycle bypass of empty channels: define CDB_BYPASS_EN.
module complete_cdb_arbiter #(
  parameter int NUM_CH = 8,
  parameter int CDB_W  = 2,
  parameter int XLEN   = 32,
  parameter int PREG_W = 6,
  parameter int ROB_W  = 5
) (
  input logic                    clock,
  input logic                    reset,
  input logic                    squash,
  complete_cdb_arbiter_if.slave  bus
);
  localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0] buf_valid;
  logic [PREG_W-1:0] buf_dest [NUM_CH];
  logic [XLEN-1:0]   buf_data [NUM_CH];
  logic [ROB_W-1:0]  buf_rob  [NUM_CH];
  logic [PTR_W-1:0]  rr_ptr;
  logic [PTR_W-1:0]  rr_next;

  logic              blocked;
  logic [NUM_CH-1:0] grant;
  logic [NUM_CH-1:0] accept;
  logic [NUM_CH-1:0] bypassed;
  logic [XLEN-1:0]   in_data [NUM_CH];
  logic [PTR_W-1:0]  lane_src [CDB_W];
  logic [CDB_W-1:0]  lane_used;
  logic [CDB_W-1:0]  lane_byp;

  // Reset is async, so gating here keeps every output low while it is held.
  assign blocked = reset | squash;

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      in_data[i] = bus.in_take_br[i] ? bus.in_npc[i*XLEN +: XLEN]
                                     : bus.in_result[i*XLEN +: XLEN];
    end
  end

  always_comb begin
    int c;
    int cnt;
    c         = 0;
    cnt       = 0;
    grant     = '0;
    lane_used = '0;
    lane_byp  = '0;
    rr_next   = rr_ptr;
    for (int k = 0; k < CDB_W; k++) lane_src[k] = '0;
    if (!blocked) begin
      for (int j = 0; j < NUM_CH; j++) begin
        c = int'(rr_ptr) + j;
        if (c >= NUM_CH) c = c - NUM_CH;
        if (buf_valid[c] && cnt < CDB_W) begin
          grant[c]      = 1'b1;
          lane_src[cnt] = PTR_W'(c);
          lane_used[cnt] = 1'b1;
          cnt           = cnt + 1;
          rr_next       = (c == NUM_CH - 1) ? '0 : PTR_W'(c + 1);
        end
      end
`ifdef CDB_BYPASS_EN
      // Empty channels with fresh input rank behind every buffered one.
      for (int j = 0; j < NUM_CH; j++) begin
        c = int'(rr_ptr) + j;
        if (c >= NUM_CH) c = c - NUM_CH;
        if (!buf_valid[c] && bus.in_valid[c] && cnt < CDB_W) begin
          grant[c]       = 1'b1;
          lane_src[cnt]  = PTR_W'(c);
          lane_used[cnt] = 1'b1;
          lane_byp[cnt]  = 1'b1;
          cnt            = cnt + 1;
          rr_next        = (c == NUM_CH - 1) ? '0 : PTR_W'(c + 1);
        end
      end
`endif
    end
  end

  always_comb begin
    int s;
    s               = 0;
    bus.cdb_valid   = lane_used;
    bus.cdb_wr_en   = '0;
    bus.cdb_idx     = '0;
    bus.cdb_data    = '0;
    bus.cdb_rob_idx = '0;
    for (int k = 0; k < CDB_W; k++) begin
      s = int'(lane_src[k]);
      if (lane_used[k]) begin
        if (lane_byp[k]) begin
          bus.cdb_idx[k*PREG_W +: PREG_W]    = bus.in_dest_idx[s*PREG_W +: PREG_W];
          bus.cdb_data[k*XLEN +: XLEN]       = in_data[s];
          bus.cdb_rob_idx[k*ROB_W +: ROB_W]  = bus.in_rob_idx[s*ROB_W +: ROB_W];
        end else begin
          bus.cdb_idx[k*PREG_W +: PREG_W]    = buf_dest[s];
          bus.cdb_data[k*XLEN +: XLEN]       = buf_data[s];
          bus.cdb_rob_idx[k*ROB_W +: ROB_W]  = buf_rob[s];
        end
        // Zero-register completions still broadcast so the ROB can retire them.
        bus.cdb_wr_en[k] = (bus.cdb_idx[k*PREG_W +: PREG_W] != '0);
      end
    end
  end

  assign bus.fu_free  = grant;
  assign bus.in_ready = blocked ? '0 : (~buf_valid | grant);
  assign accept       = bus.in_valid & bus.in_ready;
  assign bypassed     = grant & ~buf_valid;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      buf_valid <= '0;
      rr_ptr    <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        buf_dest[i] <= '0;
        buf_data[i] <= '0;
        buf_rob[i]  <= '0;
      end
    end else if (squash) begin
      buf_valid <= '0;
      rr_ptr    <= '0;
    end else begin
      buf_valid <= (buf_valid & ~grant) | (accept & ~bypassed);
      rr_ptr    <= rr_next;
      for (int i = 0; i < NUM_CH; i++) begin
        if (accept[i] && !bypassed[i]) begin
          buf_dest[i] <= bus.in_dest_idx[i*PREG_W +: PREG_W];
          buf_data[i] <= in_data[i];
          buf_rob[i]  <= bus.in_rob_idx[i*ROB_W +: ROB_W];
        end
      end
    end
  end
endmodule

// File: tb/tb_complete_cdb_arbiter.sv
// tb/tb_complete_cdb_arbiter.sv - directed self-checking bench for complete_cdb_arbiter.
module tb_complete_cdb_arbiter;
  localparam int NUM_CH = 8;
  localparam int CDB_W  = 2;
  localparam int XLEN   = 32;
  localparam int PREG_W = 6;
  localparam int ROB_W  = 5;

  logic clock;
  logic reset;
  logic squash;
  int   n_checks = 0;
  int   n_fail   = 0;

  complete_cdb_arbiter_if #(
    .NUM_CH(NUM_CH), .CDB_W(CDB_W), .XLEN(XLEN), .PREG_W(PREG_W), .ROB_W(ROB_W)
  ) bus_if ();

  complete_cdb_arbiter #(
    .NUM_CH(NUM_CH), .CDB_W(CDB_W), .XLEN(XLEN), .PREG_W(PREG_W), .ROB_W(ROB_W)
  ) dut (
    .clock (clock),
    .reset (reset),
    .squash(squash),
    .bus   (bus_if)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic clear_inputs();
    bus_if.in_valid    = '0;
    bus_if.in_dest_idx = '0;
    bus_if.in_result   = '0;
    bus_if.in_npc      = '0;
    bus_if.in_take_br  = '0;
    bus_if.in_rob_idx  = '0;
  endtask

  task automatic set_ch(input int i, input logic [PREG_W-1:0] dest, input logic [XLEN-1:0] res,
                        input logic [XLEN-1:0] npc, input logic br, input logic [ROB_W-1:0] rob);
    bus_if.in_valid[i]                    = 1'b1;
    bus_if.in_dest_idx[i*PREG_W +: PREG_W] = dest;
    bus_if.in_result[i*XLEN +: XLEN]       = res;
    bus_if.in_npc[i*XLEN +: XLEN]          = npc;
    bus_if.in_take_br[i]                   = br;
    bus_if.in_rob_idx[i*ROB_W +: ROB_W]    = rob;
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset();
    clear_inputs();
    squash = 1'b0;
    reset  = 1'b1;
    next_cycle();
    next_cycle();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    set_ch(0, 6'd1, 32'h11, 32'h0, 1'b0, 5'd1);
    set_ch(1, 6'd2, 32'h22, 32'h0, 1'b0, 5'd2);
    set_ch(2, 6'd3, 32'h33, 32'h0, 1'b0, 5'd3);
    next_cycle();
    clear_inputs();
    #1;
    n_checks++;
    if (bus_if.cdb_valid !== 2'b11) begin
      n_fail++; $display("FAIL reset_pre_valid: got %b want 11", bus_if.cdb_valid);
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if (bus_if.cdb_valid !== '0 || bus_if.cdb_wr_en !== '0 || bus_if.fu_free !== '0) begin
      n_fail++; $display("FAIL reset_ctl_zero: valid %b wr_en %b fu_free %h want 0",
                         bus_if.cdb_valid, bus_if.cdb_wr_en, bus_if.fu_free);
    end
    n_checks++;
    if (bus_if.cdb_idx !== '0 || bus_if.cdb_data !== '0 || bus_if.cdb_rob_idx !== '0) begin
      n_fail++; $display("FAIL reset_lane_zero: idx %h data %h rob %h want 0",
                         bus_if.cdb_idx, bus_if.cdb_data, bus_if.cdb_rob_idx);
    end
    n_checks++;
    if (bus_if.in_ready !== 8'h00) begin
      n_fail++; $display("FAIL reset_in_ready: got %h want 00", bus_if.in_ready);
    end
    next_cycle();
    reset = 1'b0;
    @(negedge clock);
    n_checks++;
    if (bus_if.cdb_valid !== 2'b00 || bus_if.fu_free !== 8'h00) begin
      n_fail++; $display("FAIL reset_release_idle: valid %b fu_free %h want 00/00",
                         bus_if.cdb_valid, bus_if.fu_free);
    end
    n_checks++;
    if (bus_if.in_ready !== 8'hFF) begin
      n_fail++; $display("FAIL reset_release_ready: got %h want FF", bus_if.in_ready);
    end
  endtask

  task automatic test_single();
    apply_reset();
    set_ch(3, 6'd5, 32'hDEAD, 32'h0, 1'b0, 5'd7);
    @(negedge clock);
    n_checks++;
    if (bus_if.cdb_valid !== 2'b00) begin
      n_fail++; $display("FAIL single_latency: got %b want 00", bus_if.cdb_valid);
    end
    next_cycle();
    clear_inputs();
    @(negedge clock);
    n_checks++;
    if (bus_if.cdb_valid !== 2'b01 || bus_if.cdb_wr_en !== 2'b01) begin
      n_fail++; $display("FAIL single_valid: valid %b wr_en %b want 01/01",
                         bus_if.cdb_valid, bus_if.cdb_wr_en);
    end
    n_checks++;
    if (bus_if.cdb_idx !== 12'd5 || bus_if.cdb_data !== 64'hDEAD || bus_if.cdb_rob_idx !== 10'd7) begin
      n_fail++; $display("FAIL single_lane: idx %h data %h rob %h want 005/dead/007",
                         bus_if.cdb_idx, bus_if.cdb_data, bus_if.cdb_rob_idx);
    end
    n_checks++;
    if (bus_if.fu_free !== 8'h08) begin
      n_fail++; $display("FAIL single_fu_free: got %h want 08", bus_if.fu_free);
    end
    next_cycle();
    @(negedge clock);
    n_checks++;
    if (bus_if.cdb_valid !== 2'b00 || bus_if.fu_free !== 8'h00) begin
      n_fail++; $display("FAIL single_drained: valid %b fu_free %h want 00/00",
                         bus_if.cdb_valid, bus_if.fu_free);
    end
  endtask

  task automatic test_take_br();
    apply_reset();
    set_ch(1, 6'd0, 32'h55, 32'h104, 1'b1, 5'd3);
    next_cycle();
    clear_inputs();
    @(negedge clock);
    n_checks++;
    if (bus_if.cdb_valid !== 2'b01 || bus_if.cdb_wr_en !== 2'b00) begin
      n_fail++; $display("FAIL take_br_ctl: valid %b wr_en %b want 01/00",
                         bus_if.cdb_valid, bus_if.cdb_wr_en);
    end
    n_checks++;
    if (bus_if.cdb_data !== 64'h104 || bus_if.fu_free !== 8'h02) begin
      n_fail++; $display("FAIL take_br_data: data %h fu_free %h want 104/02",
                         bus_if.cdb_data, bus_if.fu_free);
    end
  endtask

  task automatic test_all_valid();
    logic [7:0]  exp_grant [5];
    logic [11:0] exp_idx   [5];
    exp_grant = '{8'h03, 8'h0C, 8'h30, 8'hC0, 8'h03};
    exp_idx   = '{12'h081, 12'h103, 12'h185, 12'h207, 12'h081};
    apply_reset();
    for (int i = 0; i < NUM_CH; i++) set_ch(i, PREG_W'(i + 1), 32'h100 + i, 32'h0, 1'b0, ROB_W'(i));
    @(negedge clock);
    n_checks++;
    if (bus_if.cdb_valid !== 2'b00 || bus_if.in_ready !== 8'hFF) begin
      n_fail++; $display("FAIL all_first: valid %b ready %h want 00/FF",
                         bus_if.cdb_valid, bus_if.in_ready);
    end
    for (int c = 0; c < 5; c++) begin
      next_cycle();
      @(negedge clock);
      n_checks++;
      if (bus_if.fu_free !== exp_grant[c] || bus_if.in_ready !== exp_grant[c]) begin
        n_fail++; $display("FAIL all_grant[%0d]: fu_free %h ready %h want %h",
                           c, bus_if.fu_free, bus_if.in_ready, exp_grant[c]);
      end
      n_checks++;
      if (bus_if.cdb_valid !== 2'b11 || bus_if.cdb_idx !== exp_idx[c]) begin
        n_fail++; $display("FAIL all_lanes[%0d]: valid %b idx %h want 11/%h",
                           c, bus_if.cdb_valid, bus_if.cdb_idx, exp_idx[c]);
      end
    end
    clear_inputs();
  endtask

  task automatic test_back_to_back();
    apply_reset();
    set_ch(6, 6'd9, 32'hA0, 32'h0, 1'b0, 5'd0);
    for (int n = 1; n < 4; n++) begin
      next_cycle();
      set_ch(6, 6'd9, 32'hA0 + n, 32'h0, 1'b0, ROB_W'(n));
      @(negedge clock);
      n_checks++;
      if (bus_if.cdb_data[31:0] !== 32'hA0 + n - 1 || bus_if.fu_free !== 8'h40 ||
          bus_if.in_ready !== 8'hFF) begin
        n_fail++; $display("FAIL b2b[%0d]: data %h fu_free %h ready %h want %h/40/FF",
                           n, bus_if.cdb_data[31:0], bus_if.fu_free, bus_if.in_ready, 32'hA0 + n - 1);
      end
    end
    next_cycle();
    clear_inputs();
    @(negedge clock);
    n_checks++;
    if (bus_if.cdb_data[31:0] !== 32'hA3 || bus_if.cdb_valid !== 2'b01) begin
      n_fail++; $display("FAIL b2b_last: data %h valid %b want A3/01",
                         bus_if.cdb_data[31:0], bus_if.cdb_valid);
    end
  endtask

  task automatic test_squash();
    apply_reset();
    set_ch(3, 6'd3, 32'h3, 32'h0, 1'b0, 5'd3);
    next_cycle();
    clear_inputs();
    set_ch(2, 6'd2, 32'h2, 32'h0, 1'b0, 5'd2);
    set_ch(5, 6'd5, 32'h5, 32'h0, 1'b0, 5'd5);
    @(negedge clock);
    n_checks++;
    if (bus_if.fu_free !== 8'h08) begin
      n_fail++; $display("FAIL squash_setup: fu_free %h want 08", bus_if.fu_free);
    end
    next_cycle();
    clear_inputs();
    squash = 1'b1;
    set_ch(0, 6'd4, 32'h4, 32'h0, 1'b0, 5'd4);
    @(negedge clock);
    n_checks++;
    if (bus_if.cdb_valid !== 2'b00 || bus_if.fu_free !== 8'h00 || bus_if.in_ready !== 8'h00) begin
      n_fail++; $display("FAIL squash_cycle: valid %b fu_free %h ready %h want 00/00/00",
                         bus_if.cdb_valid, bus_if.fu_free, bus_if.in_ready);
    end
    next_cycle();
    squash = 1'b0;
    clear_inputs();
    @(negedge clock);
    n_checks++;
    if (bus_if.cdb_valid !== 2'b00 || bus_if.fu_free !== 8'h00) begin
      n_fail++; $display("FAIL squash_after: valid %b fu_free %h want 00/00",
                         bus_if.cdb_valid, bus_if.fu_free);
    end
    set_ch(7, 6'd7, 32'h7, 32'h0, 1'b0, 5'd7);
    set_ch(1, 6'd1, 32'h1, 32'h0, 1'b0, 5'd1);
    next_cycle();
    clear_inputs();
    @(negedge clock);
    n_checks++;
    if (bus_if.cdb_idx !== 12'h1C1 || bus_if.fu_free !== 8'h82) begin
      n_fail++; $display("FAIL squash_rr_ptr: idx %h fu_free %h want 1C1/82",
                         bus_if.cdb_idx, bus_if.fu_free);
    end
  endtask

`ifdef CDB_BYPASS_EN
  task automatic test_bypass();
    apply_reset();
    set_ch(4, 6'd12, 32'hBEEF, 32'h0, 1'b0, 5'd9);
    #1;
    n_checks++;
    if (bus_if.cdb_valid !== 2'b01 || bus_if.fu_free !== 8'h10 || bus_if.in_ready[4] !== 1'b1 ||
        bus_if.cdb_data[31:0] !== 32'hBEEF) begin
      n_fail++; $display("FAIL bypass_same_cycle: valid %b fu_free %h data %h want 01/10/BEEF",
                         bus_if.cdb_valid, bus_if.fu_free, bus_if.cdb_data[31:0]);
    end
    next_cycle();
    clear_inputs();
    @(negedge clock);
    n_checks++;
    if (bus_if.cdb_valid !== 2'b00) begin
      n_fail++; $display("FAIL bypass_not_stored: valid %b want 00", bus_if.cdb_valid);
    end
  endtask
`endif

  initial begin
    reset  = 1'b1;
    squash = 1'b0;
    clear_inputs();
`ifdef CDB_BYPASS_EN
    test_bypass();
`else
    test_reset();
    test_single();
    test_take_br();
    test_all_valid();
    test_back_to_back();
    test_squash();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
